pipe_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the en/clear pair of every pipeline register: IF PC, ID, EX, MEM, WB.
- Detects load-use hazards and control redirects (branch/jal/jalr).
- Runs the start/done handshake to the multi-cycle MUL/DIV unit and the data-memory ack wait, with a watchdog timeout.

---
 rtl/pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage RISC-V pipeline. Drives the
// enable/clear pair of every pipeline register (IF PC, ID, EX, MEM, WB).
// It detects load-use hazards and control redirects, runs the start/done
// handshake with the multi-cycle MUL/DIV unit, and waits for the data-memory
// ack. A watchdog forces the memory wait to end after a timeout.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   When defined, the stall_cnt/flush_cnt performance counters are added.
//
// Parameters
//   MEM_TIMEOUT  cycles to wait for dmem_ack before forced release (0 = off)
//   CNT_W        performance counter width (HAZARD_PERF_CNT_EN only)
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   Rs1D, Rs2D, RegReadD     ID source indices and read-enables {rs1, rs2}
//   RdE, MemToRegE           EX destination index and "EX is a load" flag
//   BranchTakenE, JalrE      redirect resolved in EX
//   JalD                     jal in ID
//   MduOpE, mdu_done         MUL/DIV request in EX and level done from the MDU
//   dmem_req_m, dmem_ack     MEM stage outstanding access and its completion
//   mdu_start                one-cycle MDU launch pulse
//   bus_err                  one-cycle pulse on watchdog expiry
//   en_F..en_W               register enables (0 = hold)
//   clr_D..clr_W             register clears (effective with matching en=1)
//   stall_cnt, flush_cnt     perf counters (HAZARD_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
// state  | meaning
// M_IDLE | no MDU operation in flight
// M_BUSY | MDU launched, waiting for mdu_done
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [1:0]       RegReadD,
  input  logic [4:0]       RdE,
  input  logic             MemToRegE,
  input  logic             BranchTakenE,
  input  logic             JalrE,
  input  logic             JalD,
  input  logic             MduOpE,
  input  logic             mdu_done,
  input  logic             dmem_req_m,
  input  logic             dmem_ack,
  output logic             mdu_start,
  output logic             bus_err,
  output logic             en_F,
  output logic             en_D,
  output logic             en_E,
  output logic             en_M,
  output logic             en_W,
  output logic             clr_D,
  output logic             clr_E,
  output logic             clr_M,
  output logic             clr_W
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic {M_IDLE, M_BUSY} mdu_state_e;

  // Counter only needs to reach MEM_TIMEOUT-1.
  localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (MEM_TIMEOUT > 0) ? WD_W'(MEM_TIMEOUT - 1) : '0;
  localparam bit WD_ON = (MEM_TIMEOUT != 0);

  mdu_state_e      mdu_q, mdu_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic mem_pend, wd_hit, mem_stall, mdu_stall, load_use, redirect_e;
  logic start_now;
  logic flush_redirect;

  // ---------------------------------------------------------------------------
  // Memory wait and watchdog
  // ---------------------------------------------------------------------------
  assign mem_pend  = dmem_req_m & ~dmem_ack;
  // Qualified by a pending access so a dropped request that left the count at
  // the last value cannot raise a spurious bus_err.
  assign wd_hit    = WD_ON & mem_pend & (wd_q == WD_LAST);
  assign mem_stall = mem_pend & ~wd_hit;
  assign wd_d      = (WD_ON && mem_stall) ? wd_q + WD_W'(1) : '0;

  // ---------------------------------------------------------------------------
  // MDU handshake
  // ---------------------------------------------------------------------------
  assign start_now = (mdu_q == M_IDLE) & MduOpE & ~mem_stall;
  assign mdu_stall = start_now | ((mdu_q == M_BUSY) & (~mdu_done | mem_stall));

  always_comb begin
    mdu_d = mdu_q;
    case (mdu_q)
      M_IDLE: if (start_now)              mdu_d = M_BUSY;
      M_BUSY: if (mdu_done && !mem_stall) mdu_d = M_IDLE;
      default:                            mdu_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_q <= M_IDLE;
      wd_q  <= '0;
    end else begin
      mdu_q <= mdu_d;
      wd_q  <= wd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard detection and priority resolution
  // ---------------------------------------------------------------------------
  assign load_use = MemToRegE & (RdE != 5'd0) &
                    ((RegReadD[1] & (Rs1D == RdE)) | (RegReadD[0] & (Rs2D == RdE)));
  assign redirect_e = BranchTakenE | JalrE;

  always_comb begin
    en_F = 1'b1; en_D = 1'b1; en_E = 1'b1; en_M = 1'b1; en_W = 1'b1;
    clr_D = 1'b0; clr_E = 1'b0; clr_M = 1'b0; clr_W = 1'b0;
    mdu_start      = 1'b0;
    bus_err        = 1'b0;
    flush_redirect = 1'b0;
    if (!rst_n) begin
      // Outputs follow reset immediately, not at the next edge.
      clr_D = 1'b1; clr_E = 1'b1; clr_M = 1'b1; clr_W = 1'b1;
    end else begin
      mdu_start = start_now;
      bus_err   = wd_hit;
      if (mem_stall) begin
        en_F = 1'b0; en_D = 1'b0; en_E = 1'b0; en_M = 1'b0;
        clr_W = 1'b1;
      end else if (mdu_stall) begin
        en_F = 1'b0; en_D = 1'b0; en_E = 1'b0;
        clr_M = 1'b1;
      end else if (redirect_e) begin
        // An EX redirect kills the dependent instruction in ID anyway, so it
        // takes precedence over the load-use bubble.
        clr_D = 1'b1; clr_E = 1'b1;
        flush_redirect = 1'b1;
      end else if (load_use) begin
        en_F = 1'b0; en_D = 1'b0;
        clr_E = 1'b1;
      end else if (JalD) begin
        clr_D = 1'b1;
        flush_redirect = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!en_F)          stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_redirect) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
